// File: rtl/cdp_ocvt_pkg.sv
// Shared constants and types for the CDP output converter channel blocks.
package cdp_ocvt_pkg;

  localparam int unsigned CDP_OCVT_OUT_DATA_W    = 128;
  localparam int unsigned CDP_OCVT_OUT_BUF_DEPTH = 2;

  typedef logic [1:0] cdp_ocvt_lvl_t;

endpackage

// File: rtl/cdp_ocvt_chn_data_out_rsco_ctrl_if.sv
// Core-side wait-protocol signals and downstream valid/ready channel of chn_data_out.
interface cdp_ocvt_chn_data_out_rsco_ctrl_if
  import cdp_ocvt_pkg::*;
#(
  parameter int unsigned DATA_W = CDP_OCVT_OUT_DATA_W
);

  logic              core_wten;
  logic              chn_data_out_rsco_iswt0;
  logic              chn_data_out_rsco_ld_core_psct;
  logic [DATA_W-1:0] chn_data_out_rsco_d_core;
  logic              chn_data_out_rsco_wen_comp;
  logic              chn_data_out_rsco_ld_core_sct;
  logic              chn_data_out_rsco_biwt;
  logic              chn_data_out_valid;
  logic              chn_data_out_ready;
  logic [DATA_W-1:0] chn_data_out_pd;
  cdp_ocvt_lvl_t     chn_data_out_lvl;

  // Controller view.
  modport slave (
    input  core_wten, chn_data_out_rsco_iswt0, chn_data_out_rsco_ld_core_psct,
           chn_data_out_rsco_d_core, chn_data_out_ready,
    output chn_data_out_rsco_wen_comp, chn_data_out_rsco_ld_core_sct, chn_data_out_rsco_biwt,
           chn_data_out_valid, chn_data_out_pd, chn_data_out_lvl
  );

  // Core plus downstream view.
  modport master (
    output core_wten, chn_data_out_rsco_iswt0, chn_data_out_rsco_ld_core_psct,
           chn_data_out_rsco_d_core, chn_data_out_ready,
    input  chn_data_out_rsco_wen_comp, chn_data_out_rsco_ld_core_sct, chn_data_out_rsco_biwt,
           chn_data_out_valid, chn_data_out_pd, chn_data_out_lvl
  );

endinterface

// File: rtl/cdp_ocvt_out_skid_buf.sv
// Two-entry registered output buffer: push at tail, pop at head on valid & ready.
module cdp_ocvt_out_skid_buf
  import cdp_ocvt_pkg::*;
#(
  parameter int unsigned DATA_W = CDP_OCVT_OUT_DATA_W
) (
  input  logic              nvdla_core_clk,
  input  logic              nvdla_core_rst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] pd_o,
  output cdp_ocvt_lvl_t     lvl_o
);

  logic [DATA_W-1:0] mem_q [CDP_OCVT_OUT_BUF_DEPTH];
  logic              head_q;
  logic              tail_q;
  cdp_ocvt_lvl_t     count_q;
  cdp_ocvt_lvl_t     count_d;
  logic              pop;

  assign valid_o = (count_q != 2'd0);
  assign pop     = valid_o & ready_i;
  assign pd_o    = mem_q[head_q];
  assign lvl_o   = count_q;

  // Push is never issued when full, so push+pop only happens at count 1.
  always_comb begin
    count_d = count_q;
    unique case ({push_i, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      for (int i = 0; i < CDP_OCVT_OUT_BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[tail_q] <= push_data_i;
        tail_q        <= ~tail_q;
      end
      if (pop) begin
        head_q <= ~head_q;
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/cdp_ocvt_chn_data_out_rsco_ctrl.sv
// chn_data_out write-side wait control: accepts core writes into a 2-entry buffer and
// stalls the core via the pending-write flag while the buffer is full.
module cdp_ocvt_chn_data_out_rsco_ctrl
  import cdp_ocvt_pkg::*;
#(
  parameter int unsigned DATA_W    = CDP_OCVT_OUT_DATA_W,
  parameter int unsigned BUF_DEPTH = CDP_OCVT_OUT_BUF_DEPTH
) (
  input logic                              nvdla_core_clk,
  input logic                              nvdla_core_rst,
  cdp_ocvt_chn_data_out_rsco_ctrl_if.slave chn
);

  localparam cdp_ocvt_lvl_t FullLvl = cdp_ocvt_lvl_t'(BUF_DEPTH);

  logic          icwt_q;
  logic          pdswt0;
  logic          ogwt;
  logic          ld_core_sct;
  logic          biwt;
  logic          full;
  cdp_ocvt_lvl_t lvl;

  assign pdswt0      = ~chn.core_wten & chn.chn_data_out_rsco_iswt0;
  assign ogwt        = pdswt0 | icwt_q;
  assign ld_core_sct = ogwt & chn.chn_data_out_rsco_ld_core_psct;
  // Full is judged on registered count only; no ready-to-core combinational path.
  assign full        = (lvl == FullLvl);
  assign biwt        = ld_core_sct & ~full;

  assign chn.chn_data_out_rsco_ld_core_sct = ld_core_sct;
  assign chn.chn_data_out_rsco_biwt        = biwt;
  assign chn.chn_data_out_rsco_wen_comp    = ~ogwt | biwt;
  assign chn.chn_data_out_lvl              = lvl;

  // A blocked write stays pending and retries regardless of core_wten.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      icwt_q <= 1'b0;
    end else begin
      icwt_q <= ogwt & ~biwt;
    end
  end

  cdp_ocvt_out_skid_buf #(
    .DATA_W (DATA_W)
  ) u_skid_buf (
    .nvdla_core_clk (nvdla_core_clk),
    .nvdla_core_rst (nvdla_core_rst),
    .push_i         (biwt),
    .push_data_i    (chn.chn_data_out_rsco_d_core),
    .ready_i        (chn.chn_data_out_ready),
    .valid_o        (chn.chn_data_out_valid),
    .pd_o           (chn.chn_data_out_pd),
    .lvl_o          (lvl)
  );

endmodule

// File: tb/tb_cdp_ocvt_chn_data_out_rsco_ctrl.sv
// Directed bench: stimulus pushes expected words, a negedge monitor pops and compares.
module tb_cdp_ocvt_chn_data_out_rsco_ctrl;

  localparam int unsigned DW = 128;

  logic nvdla_core_clk = 1'b0;
  logic nvdla_core_rst = 1'b1;

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] exp_q [$];

  cdp_ocvt_chn_data_out_rsco_ctrl_if #(.DATA_W(DW)) bus ();

  cdp_ocvt_chn_data_out_rsco_ctrl #(
    .DATA_W    (DW),
    .BUF_DEPTH (2)
  ) dut (
    .nvdla_core_clk (nvdla_core_clk),
    .nvdla_core_rst (nvdla_core_rst),
    .chn            (bus)
  );

  always #5 nvdla_core_clk = ~nvdla_core_clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge.
  task automatic step(input logic wten, input logic iswt0, input logic psct,
                      input logic [DW-1:0] d, input logic rdy);
    @(posedge nvdla_core_clk);
    #1;
    bus.core_wten                      = wten;
    bus.chn_data_out_rsco_iswt0        = iswt0;
    bus.chn_data_out_rsco_ld_core_psct = psct;
    bus.chn_data_out_rsco_d_core       = d;
    bus.chn_data_out_ready             = rdy;
  endtask

  task automatic settle();
    #2;
  endtask

  // Monitor: pop on handshake, check hold-while-stalled and level bound.
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_pd    = '0;

  always @(negedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      prev_stall = 1'b0;
    end else begin
      check("lvl_le_2", {127'd0, (bus.chn_data_out_lvl <= 2'd2)}, 128'd1);
      if (prev_stall) begin
        check("hold_valid", {127'd0, bus.chn_data_out_valid}, 128'd1);
        check("hold_pd", bus.chn_data_out_pd, prev_pd);
      end
      if (bus.chn_data_out_valid && bus.chn_data_out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", bus.chn_data_out_pd, '1);
        end else begin
          check("pd_order", bus.chn_data_out_pd, exp_q.pop_front());
        end
      end
      prev_stall = bus.chn_data_out_valid & ~bus.chn_data_out_ready;
      prev_pd    = bus.chn_data_out_pd;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    logic offered;
    int waited;
    bus.core_wten                      = 1'b0;
    bus.chn_data_out_rsco_iswt0        = 1'b0;
    bus.chn_data_out_rsco_ld_core_psct = 1'b0;
    bus.chn_data_out_rsco_d_core       = '0;
    bus.chn_data_out_ready             = 1'b0;

    // Reset then idle
    repeat (2) @(posedge nvdla_core_clk);
    #1 nvdla_core_rst = 1'b0;
    settle();
    check("rst_valid", {127'd0, bus.chn_data_out_valid}, 128'd0);
    check("rst_lvl", {126'd0, bus.chn_data_out_lvl}, 128'd0);
    check("rst_wen_comp", {127'd0, bus.chn_data_out_rsco_wen_comp}, 128'd1);
    check("rst_pd", bus.chn_data_out_pd, 128'd0);
    step(0, 0, 0, 128'h77, 0);
    settle();
    check("idle_lvl", {126'd0, bus.chn_data_out_lvl}, 128'd0);
    check("idle_biwt", {127'd0, bus.chn_data_out_rsco_biwt}, 128'd0);

    // Single write
    step(0, 1, 1, 128'h1234, 1);
    exp_q.push_back(128'h1234);
    settle();
    check("sw_biwt", {127'd0, bus.chn_data_out_rsco_biwt}, 128'd1);
    check("sw_wen_comp", {127'd0, bus.chn_data_out_rsco_wen_comp}, 128'd1);
    check("sw_sct", {127'd0, bus.chn_data_out_rsco_ld_core_sct}, 128'd1);
    check("sw_no_bypass", {127'd0, bus.chn_data_out_valid}, 128'd0);
    step(0, 0, 0, 0, 1);
    settle();
    check("sw_valid", {127'd0, bus.chn_data_out_valid}, 128'd1);
    check("sw_pd", bus.chn_data_out_pd, 128'h1234);
    step(0, 0, 0, 0, 1);
    settle();
    check("sw_drained", {127'd0, bus.chn_data_out_valid}, 128'd0);
    check("sw_lvl0", {126'd0, bus.chn_data_out_lvl}, 128'd0);

    // Backpressure fill and stall
    step(0, 1, 1, 128'hA1, 0);
    exp_q.push_back(128'hA1);
    settle();
    check("bp_a1_biwt", {127'd0, bus.chn_data_out_rsco_biwt}, 128'd1);
    step(0, 1, 1, 128'hA2, 0);
    exp_q.push_back(128'hA2);
    settle();
    check("bp_a2_biwt", {127'd0, bus.chn_data_out_rsco_biwt}, 128'd1);
    check("bp_lvl1", {126'd0, bus.chn_data_out_lvl}, 128'd1);
    step(0, 1, 1, 128'hA3, 0);
    exp_q.push_back(128'hA3);
    settle();
    check("bp_lvl2", {126'd0, bus.chn_data_out_lvl}, 128'd2);
    check("bp_a3_blocked", {127'd0, bus.chn_data_out_rsco_biwt}, 128'd0);
    check("bp_a3_stall", {127'd0, bus.chn_data_out_rsco_wen_comp}, 128'd0);
    step(1, 1, 1, 128'hA3, 1);
    settle();
    check("bp_icwt_stall", {127'd0, bus.chn_data_out_rsco_wen_comp}, 128'd0);
    check("bp_still_full", {127'd0, bus.chn_data_out_rsco_biwt}, 128'd0);
    check("bp_pd_a1", bus.chn_data_out_pd, 128'hA1);
    step(1, 1, 1, 128'hA3, 1);
    settle();
    check("bp_a3_accept", {127'd0, bus.chn_data_out_rsco_biwt}, 128'd1);
    check("bp_a3_wen", {127'd0, bus.chn_data_out_rsco_wen_comp}, 128'd1);
    check("bp_pd_a2", bus.chn_data_out_pd, 128'hA2);
    step(0, 0, 0, 0, 1);
    settle();
    check("bp_pd_a3", bus.chn_data_out_pd, 128'hA3);
    check("bp_wen_idle", {127'd0, bus.chn_data_out_rsco_wen_comp}, 128'd1);
    step(0, 0, 0, 0, 1);
    settle();
    check("bp_lvl0", {126'd0, bus.chn_data_out_lvl}, 128'd0);

    // Simultaneous push/pop at lvl=1
    for (int k = 1; k <= 4; k++) begin
      step(0, 1, 1, DW'(k), 1);
      exp_q.push_back(DW'(k));
      settle();
      check("pp_biwt", {127'd0, bus.chn_data_out_rsco_biwt}, 128'd1);
      if (k > 1) begin
        check("pp_lvl1", {126'd0, bus.chn_data_out_lvl}, 128'd1);
        check("pp_pd", bus.chn_data_out_pd, DW'(k - 1));
      end
    end
    step(0, 0, 0, 0, 1);
    settle();
    check("pp_pd_last", bus.chn_data_out_pd, 128'd4);
    step(0, 0, 0, 0, 1);
    settle();
    check("pp_lvl0", {126'd0, bus.chn_data_out_lvl}, 128'd0);

    // Ready toggling with a continuous write stream; core holds a word until accepted
    idx = 0;
    offered = 1'b0;
    for (int cyc = 0; cyc < 40 && idx < 8; cyc++) begin
      if (!offered) begin
        exp_q.push_back(128'h50 + DW'(idx));
        offered = 1'b1;
      end
      step(0, 1, 1, 128'h50 + DW'(idx), (cyc % 2) == 0);
      settle();
      if (bus.chn_data_out_rsco_biwt) begin
        idx++;
        offered = 1'b0;
      end
    end
    check("rt_all_accepted", DW'(idx), 128'd8);
    waited = 0;
    do begin
      step(0, 0, 0, 0, 1);
      settle();
      waited++;
    end while (bus.chn_data_out_lvl != 2'd0 && waited < 10);
    check("rt_drained", {126'd0, bus.chn_data_out_lvl}, 128'd0);

    // Reset mid-operation with lvl=2 and a pending write
    step(0, 1, 1, 128'hB1, 0);
    exp_q.push_back(128'hB1);
    step(0, 1, 1, 128'hB2, 0);
    exp_q.push_back(128'hB2);
    step(0, 1, 1, 128'hB3, 0);
    settle();
    check("mr_lvl2", {126'd0, bus.chn_data_out_lvl}, 128'd2);
    step(1, 1, 0, 0, 0);
    nvdla_core_rst = 1'b1;
    exp_q.delete();
    settle();
    check("mr_icwt_set", {127'd0, bus.chn_data_out_rsco_wen_comp}, 128'd0);
    @(posedge nvdla_core_clk);
    #1 nvdla_core_rst = 1'b0;
    settle();
    check("mr_lvl0", {126'd0, bus.chn_data_out_lvl}, 128'd0);
    check("mr_valid0", {127'd0, bus.chn_data_out_valid}, 128'd0);
    check("mr_wen_comp", {127'd0, bus.chn_data_out_rsco_wen_comp}, 128'd1);
    step(0, 1, 1, 128'hC1, 1);
    exp_q.push_back(128'hC1);
    settle();
    check("mr_c1_biwt", {127'd0, bus.chn_data_out_rsco_biwt}, 128'd1);
    step(0, 0, 0, 0, 1);
    settle();
    check("mr_c1_first", bus.chn_data_out_pd, 128'hC1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    settle();
    check("sb_empty", DW'(exp_q.size()), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
